bcd_down_timer: RTL and testbench

BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

---
 rtl/bcd_down_timer.sv | 122 ++++++++++++
 tb/tb_bcd_down_timer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_down_timer.sv
// Two-digit BCD down-counter with load, start/pause control and a one-cycle
// expiry pulse; optionally reloads the last loaded value and keeps running.
module bcd_down_timer #(
    parameter int AUTO_RELOAD = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       start,
    input  logic       pause,
    input  logic       tick,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       paused,
    output logic       done,
    output logic       zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam bit AUTO_RELOAD_EN = (AUTO_RELOAD != 0);

    state_t     state_q, state_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic [3:0] rel_tens_q, rel_tens_d;
    logic [3:0] rel_ones_q, rel_ones_d;
    logic       done_q, done_d;

    logic       count_zero;
    logic       count_one;
    logic       start_only;
    logic       pause_only;
    logic [3:0] clamp_tens;
    logic [3:0] clamp_ones;

    assign count_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
    assign count_one  = (tens_q == 4'd0) && (ones_q == 4'd1);
    assign start_only = start && !pause;
    assign pause_only = pause && !start;
    assign clamp_tens = (load_tens > 4'd9) ? 4'd9 : load_tens;
    assign clamp_ones = (load_ones > 4'd9) ? 4'd9 : load_ones;

    always_comb begin
        state_d    = state_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        rel_tens_d = rel_tens_q;
        rel_ones_d = rel_ones_q;
        done_d     = 1'b0;

        if (load) begin
            tens_d     = clamp_tens;
            ones_d     = clamp_ones;
            rel_tens_d = clamp_tens;
            rel_ones_d = clamp_ones;
            state_d    = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (start_only && !count_zero) state_d = RUN;
                RUN:     if (pause_only) state_d = PAUSE;
                PAUSE:   if (start_only) state_d = RUN;
                default: state_d = IDLE;
            endcase

            // The cycle showing done is the reload slot: any tick in it is dropped.
            if (AUTO_RELOAD_EN && done_q) begin
                tens_d = rel_tens_q;
                ones_d = rel_ones_q;
                if ((rel_tens_q == 4'd0) && (rel_ones_q == 4'd0)) begin
                    state_d = IDLE;
                end
            end else if ((state_q == RUN) && tick && !count_zero) begin
                if (ones_q != 4'd0) begin
                    ones_d = ones_q - 4'd1;
                end else begin
                    ones_d = 4'd9;
                    tens_d = tens_q - 4'd1;
                end
                if (count_one) begin
                    done_d = 1'b1;
                    if (!AUTO_RELOAD_EN) begin
                        state_d = IDLE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
            rel_tens_q <= 4'd0;
            rel_ones_q <= 4'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            rel_tens_q <= rel_tens_d;
            rel_ones_q <= rel_ones_d;
            done_q     <= done_d;
        end
    end

    assign tens    = tens_q;
    assign ones    = ones_q;
    assign running = (state_q == RUN);
    assign paused  = (state_q == PAUSE);
    assign done    = done_q;
    assign zero    = count_zero;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed bench for bcd_down_timer: one stop-on-expiry instance (u0) and one
// auto-reload instance (u1) share the same stimulus.
module tb_bcd_down_timer;

    logic       clk = 1'b0;
    logic       reset, load, start, pause, tick;
    logic [3:0] load_tens, load_ones;
    logic [3:0] t0, o0, t1, o1;
    logic       r0, p0, d0, z0, r1, p1, d1, z1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bcd_down_timer #(.AUTO_RELOAD(0)) u0 (
        .clk(clk), .reset(reset), .load(load), .load_tens(load_tens),
        .load_ones(load_ones), .start(start), .pause(pause), .tick(tick),
        .tens(t0), .ones(o0), .running(r0), .paused(p0), .done(d0), .zero(z0)
    );

    bcd_down_timer #(.AUTO_RELOAD(1)) u1 (
        .clk(clk), .reset(reset), .load(load), .load_tens(load_tens),
        .load_ones(load_ones), .start(start), .pause(pause), .tick(tick),
        .tens(t1), .ones(o1), .running(r1), .paused(p1), .done(d1), .zero(z1)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; load = 0; start = 0; pause = 0; tick = 0;
    endtask

    task automatic do_load(input logic [3:0] lt, input logic [3:0] lo);
        load = 1; load_tens = lt; load_ones = lo;
        cycle();
        load = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        load_tens = 4'd0; load_ones = 4'd0;
        reset = 1;
        cycle();
        cycle();
        reset = 0;
        checks++;
        if ({t0, o0, r0, p0, d0, z0} !== 12'b0000_0000_0001) begin
            errors++;
            $display("FAIL reset: got tens=%0d ones=%0d run=%b pau=%b done=%b zero=%b required 0 0 0 0 0 1",
                     t0, o0, r0, p0, d0, z0);
        end
    endtask

    task automatic test_countdown();
        logic [3:0] et, eo;
        do_load(4'd2, 4'd3);
        checks++;
        if ({t0, o0, r0} !== {4'd2, 4'd3, 1'b0}) begin
            errors++;
            $display("FAIL load_23: got %0d%0d run=%b required 23 run=0", t0, o0, r0);
        end
        start = 1;
        cycle();
        start = 0;
        checks++;
        if (r0 !== 1'b1) begin
            errors++;
            $display("FAIL start_23: running=%b required 1", r0);
        end
        tick = 1;
        for (int i = 22; i >= 0; i--) begin
            cycle();
            et = 4'(i / 10);
            eo = 4'(i % 10);
            checks++;
            if ({t0, o0, d0} !== {et, eo, (i == 0)}) begin
                errors++;
                $display("FAIL countdown_%0d: got %0d%0d done=%b required %0d%0d done=%b",
                         i, t0, o0, d0, et, eo, (i == 0));
            end
        end
        checks++;
        if ({r0, z0} !== 2'b01) begin
            errors++;
            $display("FAIL expiry_state: run=%b zero=%b required run=0 zero=1", r0, z0);
        end
        cycle();
        tick = 0;
        checks++;
        if ({t0, o0, d0, r0} !== {8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL after_expiry: got %0d%0d done=%b run=%b required 00 done=0 run=0",
                     t0, o0, d0, r0);
        end
    endtask

    task automatic test_borrow_pause();
        do_load(4'd1, 4'd0);
        start = 1; cycle(); start = 0;
        tick = 1; cycle(); tick = 0;
        checks++;
        if ({t0, o0} !== 8'h09) begin
            errors++;
            $display("FAIL borrow: got %0d%0d required 09", t0, o0);
        end
        pause = 1; cycle(); pause = 0;
        tick = 1;
        for (int i = 0; i < 5; i++) cycle();
        tick = 0;
        checks++;
        if ({t0, o0, p0, r0} !== {8'h09, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL paused_hold: got %0d%0d pau=%b run=%b required 09 pau=1 run=0",
                     t0, o0, p0, r0);
        end
        start = 1; cycle(); start = 0;
        checks++;
        if ({r0, p0} !== 2'b10) begin
            errors++;
            $display("FAIL resume: run=%b pau=%b required run=1 pau=0", r0, p0);
        end
        tick = 1; cycle(); tick = 0;
        checks++;
        if ({t0, o0} !== 8'h08) begin
            errors++;
            $display("FAIL resume_tick: got %0d%0d required 08", t0, o0);
        end
    endtask

    task automatic test_clamp_zero();
        do_load(4'd12, 4'd15);
        checks++;
        if ({t0, o0} !== 8'h99) begin
            errors++;
            $display("FAIL clamp: got %0d%0d required 99", t0, o0);
        end
        do_load(4'd0, 4'd0);
        start = 1; cycle(); start = 0;
        cycle();
        checks++;
        if ({r0, d0, z0, t0, o0} !== {1'b0, 1'b0, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL start_at_zero: run=%b done=%b zero=%b count=%0d%0d required 0 0 1 00",
                     r0, d0, z0, t0, o0);
        end
    endtask

    task automatic test_load_override();
        do_load(4'd0, 4'd5);
        start = 1; cycle(); start = 0;
        load = 1; load_tens = 4'd4; load_ones = 4'd2; tick = 1;
        cycle();
        load = 0; tick = 0;
        checks++;
        if ({t0, o0, r0} !== {8'h42, 1'b0}) begin
            errors++;
            $display("FAIL load_over_tick: got %0d%0d run=%b required 42 run=0", t0, o0, r0);
        end
        start = 1; cycle(); start = 0;
        reset = 1; load = 1; load_tens = 4'd7; load_ones = 4'd7; start = 1; tick = 1;
        cycle();
        idle_inputs();
        checks++;
        if ({t0, o0, r0, z0} !== {8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_over_all: got %0d%0d run=%b zero=%b required 00 run=0 zero=1",
                     t0, o0, r0, z0);
        end
    endtask

    task automatic test_start_pause();
        do_load(4'd0, 4'd2);
        start = 1; cycle();
        pause = 1; cycle();
        start = 0; pause = 0;
        checks++;
        if ({r0, p0} !== 2'b10) begin
            errors++;
            $display("FAIL start_and_pause: run=%b pau=%b required run=1 pau=0", r0, p0);
        end
        tick = 1; cycle();
        pause = 1; cycle();
        tick = 0; pause = 0;
        checks++;
        if ({t0, o0, d0, r0, p0} !== {8'h00, 3'b100}) begin
            errors++;
            $display("FAIL pause_expiry_noreload: got %0d%0d done=%b run=%b pau=%b required 00 1 0 0",
                     t0, o0, d0, r0, p0);
        end
        checks++;
        if ({t1, o1, d1, r1, p1} !== {8'h00, 3'b101}) begin
            errors++;
            $display("FAIL pause_expiry_reload: got %0d%0d done=%b run=%b pau=%b required 00 1 0 1",
                     t1, o1, d1, r1, p1);
        end
        cycle();
        checks++;
        if ({t1, o1, d1, p1} !== {8'h02, 2'b01}) begin
            errors++;
            $display("FAIL reload_in_pause: got %0d%0d done=%b pau=%b required 02 done=0 pau=1",
                     t1, o1, d1, p1);
        end
    endtask

    task automatic test_auto_reload();
        logic [3:0] exp_ones [8];
        logic       exp_done [8];
        exp_ones = '{4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0, 4'd3};
        exp_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_load(4'd0, 4'd3);
        start = 1; cycle(); start = 0;
        tick = 1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            checks++;
            if ({t1, o1, d1, r1} !== {4'd0, exp_ones[i], exp_done[i], 1'b1}) begin
                errors++;
                $display("FAIL auto_reload_%0d: got %0d%0d done=%b run=%b required 0%0d done=%b run=1",
                         i, t1, o1, d1, r1, exp_ones[i], exp_done[i]);
            end
        end
        tick = 0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_ones [4];
        logic       exp_done [4];
        exp_ones = '{4'd0, 4'd1, 4'd0, 4'd1};
        exp_done = '{1'b1, 1'b0, 1'b1, 1'b0};
        do_load(4'd0, 4'd1);
        start = 1; cycle(); start = 0;
        tick = 1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if ({t1, o1, d1, r1} !== {4'd0, exp_ones[i], exp_done[i], 1'b1}) begin
                errors++;
                $display("FAIL back_to_back_%0d: got %0d%0d done=%b run=%b required 0%0d done=%b run=1",
                         i, t1, o1, d1, r1, exp_ones[i], exp_done[i]);
            end
        end
        tick = 0;
        reset = 1; cycle(); reset = 0;
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_borrow_pause();
        test_clamp_zero();
        test_load_override();
        test_start_pause();
        test_auto_reload();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
